// File: rtl/resp_packer_if.sv
// Signal bundle between the response packer, its ALU/register-file sources and the
// async-FIFO write side.
interface resp_packer_if;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_Valid;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic        FIFO_FULL;
  logic        OVR_CLR;
  logic [7:0]  FIFO_WrData;
  logic        FIFO_WrInc;
  logic        BUSY;
  logic        OVERRUN;
  logic [7:0]  DROP_CNT;

  // master: the sources and FIFO surrounding the packer
  modport master (
    output ALU_OUT, ALU_OUT_Valid, RdData, RdData_Valid, FIFO_FULL, OVR_CLR,
    input  FIFO_WrData, FIFO_WrInc, BUSY, OVERRUN, DROP_CNT
  );

  // slave: the packer itself
  modport slave (
    input  ALU_OUT, ALU_OUT_Valid, RdData, RdData_Valid, FIFO_FULL, OVR_CLR,
    output FIFO_WrData, FIFO_WrInc, BUSY, OVERRUN, DROP_CNT
  );
endinterface

// File: rtl/resp_packer.sv
// Packs ALU results and register reads into header/data/XOR-checksum byte frames
// written one byte per cycle into a FIFO; responses arriving while busy are dropped and counted.
module resp_packer #(
  parameter logic [7:0] HDR_ALU = 8'hA5,
  parameter logic [7:0] HDR_RD  = 8'h5A,
  parameter bit         CHK_EN  = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  resp_packer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    B0   = 3'd2,
    B1   = 3'd3,
    CHK  = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] data_reg;
  logic        is_alu_reg;
  logic [7:0]  chk_reg;
  logic        overrun_reg;
  logic [7:0]  drop_cnt_reg;

  logic        busy;
  logic        wr_inc;
  logic [7:0]  cur_byte;
  logic        accept;
  logic        drop_alu;
  logic        drop_rd;
  logic [1:0]  drop_num;
  logic [7:0]  cnt_base;
  logic [8:0]  cnt_sum;

  assign busy   = (state_reg != IDLE);
  assign wr_inc = busy & ~bus.FIFO_FULL;
  assign accept = ~busy & (bus.ALU_OUT_Valid | bus.RdData_Valid);

  // In IDLE the ALU response has priority, so a coincident read is lost.
  assign drop_alu = busy & bus.ALU_OUT_Valid;
  assign drop_rd  = bus.RdData_Valid & (busy | bus.ALU_OUT_Valid);
  assign drop_num = {1'b0, drop_alu} + {1'b0, drop_rd};
  assign cnt_base = bus.OVR_CLR ? 8'h00 : drop_cnt_reg;
  assign cnt_sum  = {1'b0, cnt_base} + {7'b0, drop_num};

  always_comb begin
    cur_byte   = 8'h00;
    state_next = IDLE;
    case (state_reg)
      HDR: begin
        cur_byte   = is_alu_reg ? HDR_ALU : HDR_RD;
        state_next = B0;
      end
      B0: begin
        cur_byte = data_reg[7:0];
        if (is_alu_reg)
          state_next = B1;
        else
          state_next = CHK_EN ? CHK : IDLE;
      end
      B1: begin
        cur_byte   = data_reg[15:8];
        state_next = CHK_EN ? CHK : IDLE;
      end
      CHK: begin
        cur_byte   = chk_reg;
        state_next = IDLE;
      end
      default: begin
        cur_byte   = 8'h00;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.FIFO_WrInc  = wr_inc;
  assign bus.FIFO_WrData = wr_inc ? cur_byte : 8'h00;
  assign bus.BUSY        = busy;
  assign bus.OVERRUN     = overrun_reg;
  assign bus.DROP_CNT    = drop_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      data_reg     <= 16'h0000;
      is_alu_reg   <= 1'b0;
      chk_reg      <= 8'h00;
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= 8'h00;
    end else begin
      if (!busy) begin
        if (accept) begin
          state_reg  <= HDR;
          is_alu_reg <= bus.ALU_OUT_Valid;
          data_reg   <= bus.ALU_OUT_Valid ? bus.ALU_OUT : {8'h00, bus.RdData};
          chk_reg    <= 8'h00;
        end
      end else if (wr_inc) begin
        // Checksum only folds in bytes that actually reach the FIFO.
        chk_reg   <= chk_reg ^ cur_byte;
        state_reg <= state_next;
      end

      // A drop in the same cycle as a clear survives the clear.
      overrun_reg  <= (overrun_reg & ~bus.OVR_CLR) | (drop_num != 2'd0);
      drop_cnt_reg <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

endmodule

// File: tb/tb_resp_packer.sv
// Directed-vector bench for resp_packer: frame contents, stall, drop accounting,
// mid-frame reset and a build without the checksum byte.
module tb_resp_packer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  resp_packer_if bus ();
  resp_packer_if bus2 ();

  resp_packer #(.HDR_ALU(8'hA5), .HDR_RD(8'h5A), .CHK_EN(1'b1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  resp_packer #(.HDR_ALU(8'hA5), .HDR_RD(8'h5A), .CHK_EN(1'b0)) dut_nochk (
    .CLK (clk),
    .RST (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One cycle on the main DUT: sample strobe/data mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic exp_inc, input logic [7:0] exp_data);
    @(negedge clk);
    check({tag, ".inc"}, 16'(bus.FIFO_WrInc), 16'(exp_inc));
    check({tag, ".data"}, 16'(bus.FIFO_WrData), 16'(exp_data));
    if (bus.FIFO_WrInc) $display("tx %s byte=%h", tag, bus.FIFO_WrData);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input string tag, input logic exp_inc, input logic [7:0] exp_data);
    @(negedge clk);
    check({tag, ".inc"}, 16'(bus2.FIFO_WrInc), 16'(exp_inc));
    check({tag, ".data"}, 16'(bus2.FIFO_WrData), 16'(exp_data));
    if (bus2.FIFO_WrInc) $display("tx %s byte=%h", tag, bus2.FIFO_WrData);
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic busy, input logic ovr, input logic [7:0] cnt);
    check({tag, ".busy"}, 16'(bus.BUSY), 16'(busy));
    check({tag, ".ovr"}, 16'(bus.OVERRUN), 16'(ovr));
    check({tag, ".cnt"}, 16'(bus.DROP_CNT), 16'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.ALU_OUT = 16'h0000;  bus.ALU_OUT_Valid = 1'b0;
    bus.RdData  = 8'h00;     bus.RdData_Valid  = 1'b0;
    bus.FIFO_FULL = 1'b0;    bus.OVR_CLR = 1'b0;
    bus2.ALU_OUT = 16'h0000; bus2.ALU_OUT_Valid = 1'b0;
    bus2.RdData  = 8'h00;    bus2.RdData_Valid  = 1'b0;
    bus2.FIFO_FULL = 1'b0;   bus2.OVR_CLR = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_status("rst", 1'b0, 1'b0, 8'h00);
    check("rst.inc", 16'(bus.FIFO_WrInc), 16'h0);
    check("rst.data", 16'(bus.FIFO_WrData), 16'h00);
    check("rst.busy2", 16'(bus2.BUSY), 16'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ALU frame 16'h1234
    bus.ALU_OUT = 16'h1234; bus.ALU_OUT_Valid = 1'b1;
    cyc("alu.idle", 1'b0, 8'h00);
    bus.ALU_OUT_Valid = 1'b0;
    check("alu.busy", 16'(bus.BUSY), 16'h1);
    cyc("alu.hdr", 1'b1, 8'hA5);
    cyc("alu.b0", 1'b1, 8'h34);
    cyc("alu.b1", 1'b1, 8'h12);
    cyc("alu.chk", 1'b1, 8'h83);
    check("alu.done", 16'(bus.BUSY), 16'h0);
    cyc("alu.after", 1'b0, 8'h00);

    // RD frame 8'h7E, then a back-to-back frame accepted in the single idle cycle
    bus.RdData = 8'h7E; bus.RdData_Valid = 1'b1;
    cyc("rd.idle", 1'b0, 8'h00);
    bus.RdData_Valid = 1'b0;
    cyc("rd.hdr", 1'b1, 8'h5A);
    cyc("rd.b0", 1'b1, 8'h7E);
    cyc("rd.chk", 1'b1, 8'h24);
    check("b2b.idle_busy", 16'(bus.BUSY), 16'h0);
    bus.RdData = 8'hC3; bus.RdData_Valid = 1'b1;
    cyc("b2b.idle", 1'b0, 8'h00);
    bus.RdData_Valid = 1'b0;
    cyc("b2b.hdr", 1'b1, 8'h5A);
    cyc("b2b.b0", 1'b1, 8'hC3);
    cyc("b2b.chk", 1'b1, 8'h99);
    cyc("b2b.after", 1'b0, 8'h00);

    // Stall for three cycles after the header
    bus.ALU_OUT = 16'h1234; bus.ALU_OUT_Valid = 1'b1;
    cyc("stl.idle", 1'b0, 8'h00);
    bus.ALU_OUT_Valid = 1'b0;
    cyc("stl.hdr", 1'b1, 8'hA5);
    bus.FIFO_FULL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stl.busy", 16'(bus.BUSY), 16'h1);
      cyc("stl.hold", 1'b0, 8'h00);
    end
    bus.FIFO_FULL = 1'b0;
    cyc("stl.b0", 1'b1, 8'h34);
    cyc("stl.b1", 1'b1, 8'h12);
    cyc("stl.chk", 1'b1, 8'h83);
    cyc("stl.after", 1'b0, 8'h00);

    // Simultaneous valids in IDLE: ALU wins, read dropped
    bus.ALU_OUT = 16'h00FF; bus.RdData = 8'h11;
    bus.ALU_OUT_Valid = 1'b1; bus.RdData_Valid = 1'b1;
    cyc("both.idle", 1'b0, 8'h00);
    bus.ALU_OUT_Valid = 1'b0; bus.RdData_Valid = 1'b0;
    check_status("both", 1'b1, 1'b1, 8'h01);
    cyc("both.hdr", 1'b1, 8'hA5);
    cyc("both.b0", 1'b1, 8'hFF);
    cyc("both.b1", 1'b1, 8'h00);
    cyc("both.chk", 1'b1, 8'h5A);
    bus.OVR_CLR = 1'b1;
    cyc("both.clr", 1'b0, 8'h00);
    bus.OVR_CLR = 1'b0;
    check_status("both.cleared", 1'b0, 1'b0, 8'h00);

    // 300 drops with FIFO full saturate the counter
    bus.ALU_OUT = 16'h1234; bus.ALU_OUT_Valid = 1'b1; bus.FIFO_FULL = 1'b1;
    cyc("sat.idle", 1'b0, 8'h00);
    bus.ALU_OUT_Valid = 1'b0;
    bus.RdData_Valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.RdData_Valid = 1'b0;
    check_status("sat", 1'b1, 1'b1, 8'hFF);
    check("sat.inc", 16'(bus.FIFO_WrInc), 16'h0);
    $display("tx sat drop_cnt=%h", bus.DROP_CNT);
    bus.OVR_CLR = 1'b1;
    @(posedge clk);
    #1;
    check_status("sat.clr", 1'b1, 1'b0, 8'h00);
    bus.RdData_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.OVR_CLR = 1'b0;
    check_status("clr_drop", 1'b1, 1'b1, 8'h01);
    bus.ALU_OUT_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.ALU_OUT_Valid = 1'b0; bus.RdData_Valid = 1'b0;
    check_status("dbl_drop", 1'b1, 1'b1, 8'h03);
    bus.FIFO_FULL = 1'b0;
    cyc("sat.hdr", 1'b1, 8'hA5);

    // Reset during B0 (with a coincident valid) abandons the frame
    bus.ALU_OUT_Valid = 1'b1;
    rst = 1'b1;
    cyc("rmf.b0", 1'b1, 8'h34);
    check_status("rmf.reset", 1'b0, 1'b0, 8'h00);
    cyc("rmf.reset", 1'b0, 8'h00);
    rst = 1'b0;
    bus.ALU_OUT_Valid = 1'b0;
    check_status("rmf.ignored", 1'b0, 1'b0, 8'h00);
    cyc("rmf.after1", 1'b0, 8'h00);
    cyc("rmf.after2", 1'b0, 8'h00);

    // Build without checksum: read frame is header and data only
    bus2.RdData = 8'h7E; bus2.RdData_Valid = 1'b1;
    cyc2("nochk.idle", 1'b0, 8'h00);
    bus2.RdData_Valid = 1'b0;
    cyc2("nochk.hdr", 1'b1, 8'h5A);
    cyc2("nochk.b0", 1'b1, 8'h7E);
    check("nochk.busy", 16'(bus2.BUSY), 16'h0);
    cyc2("nochk.after", 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
